// File: rtl/bcd_pkg.sv
// bcd_pkg: shared scan states, sum record and 7-segment glyph helpers
package bcd_pkg;
  typedef enum logic [1:0] {S_ONES = 2'd0, S_TENS = 2'd1, S_HUND = 2'd2} scan_state_t;
  typedef struct packed {
    logic       cout;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_sum_t;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  // active-low {g,f,e,d,c,b,a}; any non-BCD nibble renders as 'E'
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return SEG_E;
    endcase
  endfunction
endpackage

// File: rtl/bcd_seg_decode.sv
// bcd_seg_decode: combinational nibble to active-low 7-segment glyph
module bcd_seg_decode
  import bcd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = bcd_to_seg(nibble);
endmodule

// File: rtl/bcd_sum_scan_display.sv
// bcd_sum_scan_display: tear-free 3-digit multiplexed display of a BCD adder sum
module bcd_sum_scan_display
  import bcd_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int LZ_BLANK     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sum_valid,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic       cout,
  output logic [2:0] an,
  output logic [6:0] seg,
  output logic       frame_done
);
  localparam int CW = $clog2(DIGIT_CYCLES);
  scan_state_t   state, state_nx;
  logic [CW-1:0] cnt;
  bcd_sum_t      shadow, disp;
  logic          pending, last, boundary, blank;
  logic [3:0]    nibble;
  logic [6:0]    glyph;
  logic [2:0]    an_nx;
  bcd_seg_decode u_dec (.nibble(nibble), .seg(glyph));
  always_comb begin
    last     = int'(cnt) == DIGIT_CYCLES - 1;
    boundary = last && state == S_HUND;
    state_nx = state == S_ONES ? S_TENS : state == S_TENS ? S_HUND : S_ONES;
    nibble   = state == S_ONES ? disp.ones : state == S_TENS ? disp.tens : {3'b000, disp.cout};
    blank    = int'(cnt) < BLANK_CYCLES || (LZ_BLANK != 0 &&
               (state == S_HUND ? !disp.cout :
                state == S_TENS ? (!disp.cout && disp.tens == 4'd0) : 1'b0));
    an_nx    = blank ? 3'b111 : state == S_ONES ? 3'b110 : state == S_TENS ? 3'b101 : 3'b011;
  end
  // a strobe on the boundary clock refills the shadow while the old shadow is shown
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_ONES;
      cnt        <= '0;
      shadow     <= '0;
      disp       <= '0;
      pending    <= 1'b0;
      an         <= 3'b111;
      seg        <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      cnt        <= last ? '0 : cnt + 1'b1;
      if (last) state <= state_nx;
      if (sum_valid) shadow <= {cout, tens, ones};
      if (boundary && pending) disp <= shadow;
      pending    <= sum_valid || (pending && !boundary);
      an         <= an_nx;
      seg        <= blank ? SEG_BLANK : glyph;
      frame_done <= boundary;
    end
  end
endmodule

// File: tb/tb_bcd_sum_scan_display.sv
// tb_bcd_sum_scan_display: directed frame-level checks of the scanned BCD display
module tb_bcd_sum_scan_display;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       sum_valid = 0;
  logic [3:0] ones = 0, tens = 0;
  logic       cout = 0;
  logic [2:0] an, an2;
  logic [6:0] seg, seg2;
  logic       frame_done, frame_done2;
  logic [263:0] fr1, fr2;
  int tests = 0, fails = 0;

  bcd_sum_scan_display #(.DIGIT_CYCLES(8), .BLANK_CYCLES(2), .LZ_BLANK(1)) dut (
    .clk(clk), .rst_n(rst_n), .sum_valid(sum_valid), .ones(ones), .tens(tens),
    .cout(cout), .an(an), .seg(seg), .frame_done(frame_done));
  bcd_sum_scan_display #(.DIGIT_CYCLES(8), .BLANK_CYCLES(2), .LZ_BLANK(0)) dut_nolz (
    .clk(clk), .rst_n(rst_n), .sum_valid(sum_valid), .ones(ones), .tens(tens),
    .cout(cout), .an(an2), .seg(seg2), .frame_done(frame_done2));

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0000110;
    endcase
  endfunction

  // expected 24 samples of {frame_done,an,seg}, starting on the first clock after a frame_done
  function automatic logic [263:0] exp_frame(input logic [8:0] v, input bit lz);
    logic [263:0] f;
    logic [3:0] nib;
    logic bl;
    int s, w;
    f = '0;
    for (int j = 0; j < 24; j++) begin
      s = j / 8;
      w = j % 8;
      nib = s == 0 ? v[3:0] : s == 1 ? v[7:4] : {3'b000, v[8]};
      bl = w < 2 || (lz && (s == 2 ? !v[8] : s == 1 ? (!v[8] && v[7:4] == 4'd0) : 1'b0));
      f[j*11 +: 11] = {j == 23, bl ? 3'b111 : s == 0 ? 3'b110 : s == 1 ? 3'b101 : 3'b011,
                       bl ? 7'h7f : glyph(nib)};
    end
    return f;
  endfunction

  task automatic grab_frame(input int j1, input logic [8:0] v1, input int j2, input logic [8:0] v2);
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      sum_valid = 0;
      fr1[j*11 +: 11] = {frame_done, an, seg};
      fr2[j*11 +: 11] = {frame_done2, an2, seg2};
      if (j == j1 || j == j2) begin
        {cout, tens, ones} = j == j1 ? v1 : v2;
        sum_valid = 1;
      end
    end
    @(negedge clk) sum_valid = 0;
    repeat (23) @(negedge clk);
  endtask

  task automatic wait_first_frame(input string name);
    int k;
    k = 0;
    while (k < 100) begin
      @(negedge clk);
      k++;
      if (frame_done) break;
    end
    tests++;
    if (k != 24) begin
      fails++;
      $display("FAIL %s first frame_done after %0d clocks, expected 24", name, k);
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(negedge clk);
    tests += 3;
    if (an !== 3'b111) begin fails++; $display("FAIL reset_an got %b exp 111", an); end
    if (seg !== 7'h7f) begin fails++; $display("FAIL reset_seg got %b exp 1111111", seg); end
    if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_fd got %b exp 0", frame_done); end
    rst_n = 1;
    wait_first_frame("reset_first_fd");
    grab_frame(-1, 0, -1, 0);
    tests++;
    if (fr1 !== exp_frame(9'h000, 1)) begin fails++; $display("FAIL idle_frame got %h exp %h", fr1, exp_frame(9'h000, 1)); end
  endtask

  task automatic grab_only(input logic [8:0] v, input string name);
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      fr1[j*11 +: 11] = {frame_done, an, seg};
      fr2[j*11 +: 11] = {frame_done2, an2, seg2};
    end
    tests++;
    if (fr1 !== exp_frame(v, 1)) begin fails++; $display("FAIL %s got %h exp %h", name, fr1, exp_frame(v, 1)); end
  endtask

  task automatic test_capture;
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      sum_valid = 0;
      fr1[j*11 +: 11] = {frame_done, an, seg};
      if (j == 10) begin {cout, tens, ones} = 9'h147; sum_valid = 1; end
    end
    tests++;
    if (fr1 !== exp_frame(9'h000, 1)) begin fails++; $display("FAIL capture_same_frame got %h exp %h", fr1, exp_frame(9'h000, 1)); end
    grab_only(9'h147, "capture_147");
  endtask

  task automatic test_back_to_back;
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      sum_valid = 0;
      fr1[j*11 +: 11] = {frame_done, an, seg};
      if (j == 3) begin {cout, tens, ones} = 9'h003; sum_valid = 1; end
      if (j == 12) begin {cout, tens, ones} = 9'h009; sum_valid = 1; end
    end
    tests++;
    if (fr1 !== exp_frame(9'h147, 1)) begin fails++; $display("FAIL b2b_hold got %h exp %h", fr1, exp_frame(9'h147, 1)); end
    grab_only(9'h009, "b2b_last_wins");
  endtask

  task automatic test_boundary_strobe;
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      sum_valid = 0;
      fr1[j*11 +: 11] = {frame_done, an, seg};
      if (j == 5) begin {cout, tens, ones} = 9'h002; sum_valid = 1; end
      if (j == 22) begin {cout, tens, ones} = 9'h005; sum_valid = 1; end
    end
    tests++;
    if (fr1 !== exp_frame(9'h009, 1)) begin fails++; $display("FAIL bnd_hold got %h exp %h", fr1, exp_frame(9'h009, 1)); end
    sum_valid = 0;
    grab_only(9'h002, "bnd_old_shadow");
    grab_only(9'h005, "bnd_new_shadow");
  endtask

  task automatic test_glyphs;
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      sum_valid = 0;
      fr1[j*11 +: 11] = {frame_done, an, seg};
      if (j == 4) begin {cout, tens, ones} = 9'h0CF; sum_valid = 1; end
    end
    tests++;
    if (fr1 !== exp_frame(9'h005, 1)) begin fails++; $display("FAIL glyph_hold got %h exp %h", fr1, exp_frame(9'h005, 1)); end
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      sum_valid = 0;
      fr1[j*11 +: 11] = {frame_done, an, seg};
      fr2[j*11 +: 11] = {frame_done2, an2, seg2};
      if (j == 4) begin {cout, tens, ones} = 9'h000; sum_valid = 1; end
    end
    tests += 2;
    if (fr1 !== exp_frame(9'h0CF, 1)) begin fails++; $display("FAIL glyph_E got %h exp %h", fr1, exp_frame(9'h0CF, 1)); end
    if (fr2 !== exp_frame(9'h0CF, 0)) begin fails++; $display("FAIL glyph_E_nolz got %h exp %h", fr2, exp_frame(9'h0CF, 0)); end
    grab_only(9'h000, "zero_lz");
    tests++;
    if (fr2 !== exp_frame(9'h000, 0)) begin fails++; $display("FAIL zero_nolz got %h exp %h", fr2, exp_frame(9'h000, 0)); end
  endtask

  task automatic test_reset_mid_frame;
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      sum_valid = 0;
      if (j == 3) begin {cout, tens, ones} = 9'h123; sum_valid = 1; end
    end
    for (int j = 0; j < 19; j++) begin
      @(negedge clk);
      sum_valid = 0;
      if (j == 3) begin {cout, tens, ones} = 9'h056; sum_valid = 1; end
    end
    rst_n = 0;
    @(negedge clk);
    tests += 3;
    if (an !== 3'b111) begin fails++; $display("FAIL midrst_an got %b exp 111", an); end
    if (seg !== 7'h7f) begin fails++; $display("FAIL midrst_seg got %b exp 1111111", seg); end
    if (frame_done !== 1'b0) begin fails++; $display("FAIL midrst_fd got %b exp 0", frame_done); end
    rst_n = 1;
    wait_first_frame("midrst_first_fd");
    grab_only(9'h000, "midrst_discard1");
    grab_only(9'h000, "midrst_discard2");
  endtask

  initial begin
    test_reset;
    test_capture;
    test_back_to_back;
    test_boundary_strobe;
    test_glyphs;
    test_reset_mid_frame;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
